// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types for the fetch front end.
//   Data/Addr/Instr : 32-bit words
//   Bool            : single-bit flag
//   NOP             : canonical RV32 no-op (addi x0, x0, 0)
//   FetchEntry      : one prefetch slot {pc, instr, filled}
package cpu_types_pkg;

  typedef logic [31:0] Data;
  typedef logic [31:0] Addr;
  typedef logic [31:0] Instr;
  typedef logic        Bool;

  localparam Instr NOP = 32'h0000_0013;

  typedef struct packed {
    Addr  pc;
    Instr instr;
    Bool  filled;
  } FetchEntry;

endpackage

// File: rtl/fetch_slot_buffer.sv
// fetch_slot_buffer: DEPTH-entry circular buffer of fetch slots.
// A slot is allocated (pc known, instruction pending) when its request is
// issued. Slots are filled strictly in allocation order and popped from the
// head once filled. Flush empties the buffer in one cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               discard every slot (takes priority over alloc/fill/pop)
//   alloc, alloc_pc     append a new unfilled slot at the tail
//   fill, fill_instr    write instruction into the oldest unfilled slot
//   pop                 remove the head slot
//   head_pc/head_instr  head slot contents
//   head_filled         buffer non-empty and head slot filled
//   count               occupied slots (0..DEPTH)
//   unfilled            allocated slots still awaiting their instruction
module fetch_slot_buffer
  import cpu_types_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [XLEN-1:0]           alloc_pc,
  input  logic                      fill,
  input  Instr                      fill_instr,
  input  logic                      pop,
  output logic [XLEN-1:0]           head_pc,
  output Instr                      head_instr,
  output logic                      head_filled,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH):0]    unfilled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  Instr             instr_mem [DEPTH];
  logic [DEPTH-1:0] filled_mem;
  logic [AW-1:0]    head, tail, fill_ptr;

  // Control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) tail     <= tail + AW'(1);
      if (fill)  fill_ptr <= fill_ptr + AW'(1);
      if (pop)   head     <= head + AW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

  // Storage: a fill never targets the slot allocated in the same cycle
  // because responses arrive at least one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[tail]     <= alloc_pc;
      filled_mem[tail] <= 1'b0;
    end
    if (fill) begin
      instr_mem[fill_ptr]  <= fill_instr;
      filled_mem[fill_ptr] <= 1'b1;
    end
  end

  assign head_pc     = pc_mem[head];
  assign head_instr  = instr_mem[head];
  assign head_filled = (count != '0) && filled_mem[head];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential-PC fetch unit with a DEPTH-entry
// prefetch queue in front of a variable-latency, in-order instruction memory.
// Each queue slot is reserved when its request is accepted, so the number of
// requests in flight never exceeds the free space. After a redirect, responses
// to requests issued before it are counted in drop_cnt and discarded.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_req/imem_addr             request valid / address (= fetch PC)
//   imem_ready                     memory accepts the request this cycle
//   imem_rvalid/imem_rdata         in-order response
//   jump_enable/jump_address       redirect from exec (low two bits ignored)
//   stall                          decode cannot consume
//   instruction_out/address_out    head entry
//   next_address_out               address_out + 4
//   valid_out                      head filled and no redirect this cycle
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed.
module fetch_prefetch_queue
  import cpu_types_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            jump_enable,
  input  logic [XLEN-1:0] jump_address,
  input  logic            stall,
  output logic [31:0]     instruction_out,
  output logic [XLEN-1:0] address_out,
  output logic [XLEN-1:0] next_address_out,
  output logic            valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt, count, unfilled;
  logic [CW:0]     credit_used;
  logic            alloc, fill, pop, head_filled;
  logic [XLEN-1:0] head_pc;
  Instr            head_instr;

  // Credit covers both live slots and responses still owed to flushed requests.
  assign credit_used = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req    = !reset && !jump_enable && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign alloc       = imem_req && imem_ready;
  assign fill        = imem_rvalid && (drop_cnt == '0) && !jump_enable && !reset;
  assign valid_out   = !reset && !jump_enable && head_filled;
  assign pop         = valid_out && !stall;

  assign instruction_out  = reset ? '0 : head_instr;
  assign address_out      = reset ? '0 : head_pc;
  assign next_address_out = reset ? '0 : head_pc + XLEN'(4);

  fetch_slot_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) u_slots (
    .clk         (clk),
    .reset       (reset),
    .flush       (jump_enable),
    .alloc       (alloc),
    .alloc_pc    (fetch_pc),
    .fill        (fill),
    .fill_instr  (imem_rdata),
    .pop         (pop),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .head_filled (head_filled),
    .count       (count),
    .unfilled    (unfilled)
  );

  always_ff @(posedge clk) begin
    if (reset)            fetch_pc <= RESET_PC;
    else if (jump_enable) fetch_pc <= jump_address & ~XLEN'(3);
    else if (alloc)       fetch_pc <= fetch_pc + XLEN'(4);
  end

  // On redirect every unfilled slot still owes a response; one returning in
  // the jump cycle itself settles one of them (or an older dropped one).
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (jump_enable)
      drop_cnt <= drop_cnt + unfilled - CW'(imem_rvalid);
    else if (imem_rvalid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - CW'(1);
  end

  assert property (@(posedge clk) disable iff (reset) drop_cnt <= CW'(DEPTH));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop)         perf_fetched <= perf_fetched + 32'd1;
      if (jump_enable) perf_flushed <= perf_flushed + 32'(count) + 32'(imem_rvalid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, imem_rvalid, jump_enable, stall, valid_out;
  logic [31:0] imem_addr, imem_rdata, jump_address, instruction_out, address_out, next_address_out;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .jump_enable      (jump_enable),
    .jump_address     (jump_address),
    .stall            (stall),
    .instruction_out  (instruction_out),
    .address_out      (address_out),
    .next_address_out (next_address_out),
    .valid_out        (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (),
    .perf_flushed     ()
`endif
  );

  // Outstanding memory request: address, redirect epoch it belongs to, earliest response cycle.
  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t        memq[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, epoch = 0, entries = 0, filled = 0;
  logic [31:0] fpc = 32'h0, exp_pc = 32'h0;
  bit          pc_known = 0;
  int          since_rel = 0, first_vld = -1, pop_cnt = 0, acc_cnt = 0;
  bit          got_first_pop = 0;
  logic [31:0] first_pop_addr = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference.
  task automatic step(input bit r, input bit j, input logic [31:0] ja, input bit st,
                      input bit rdy, input int lat, input bit rv_en);
    bit   rv, exp_req, exp_vld;
    int   stale;
    req_t e;
    @(negedge clk);
    rv = !r && rv_en && (memq.size() > 0) && (memq[0].due <= cyc);
    reset        = r;
    jump_enable  = j;
    jump_address = ja;
    stall        = st;
    imem_ready   = rdy;
    imem_rvalid  = rv;
    imem_rdata   = rv ? mem_data(memq[0].addr) : $urandom;
    #1;
    stale = 0;
    foreach (memq[i]) if (memq[i].ep != epoch) stale++;
    exp_req = !r && !j && (entries + stale < DEPTH);
    exp_vld = !r && !j && (filled > 0);
    check_val("imem_req", imem_req, exp_req);
    check_val("valid_out", valid_out, exp_vld);
    if (pc_known) check_val("imem_addr", imem_addr, fpc);
    if (r) begin
      check_val("rst_instr", instruction_out, 32'h0);
      check_val("rst_addr", address_out, 32'h0);
      check_val("rst_next_addr", next_address_out, 32'h0);
    end else if (exp_vld) begin
      check_val("address_out", address_out, exp_pc);
      check_val("instruction_out", instruction_out, mem_data(exp_pc));
      check_val("next_address_out", next_address_out, exp_pc + 32'd4);
    end
    if (!r && valid_out === 1'b1 && first_vld < 0) first_vld = since_rel;
    if (valid_out === 1'b1 && !st) begin
      pop_cnt++;
      if (!got_first_pop) begin
        got_first_pop  = 1;
        first_pop_addr = address_out;
      end
    end
    if (imem_req === 1'b1 && rdy) acc_cnt++;
    if (r) begin
      memq.delete();
      entries  = 0;
      filled   = 0;
      fpc      = RESET_PC;
      exp_pc   = RESET_PC;
      pc_known = 1;
    end else if (j) begin
      if (rv) void'(memq.pop_front());
      epoch++;
      entries = 0;
      filled  = 0;
      fpc     = ja & ~32'h3;
      exp_pc  = fpc;
    end else begin
      if (rv) begin
        e = memq.pop_front();
        if (e.ep == epoch) filled++;
      end
      if (exp_vld && !st) begin
        filled--;
        entries--;
        exp_pc += 32'd4;
      end
      if (exp_req && rdy) begin
        memq.push_back('{addr: fpc, ep: epoch, due: cyc + lat});
        entries++;
        fpc += 32'd4;
      end
    end
    if (r) begin
      since_rel = 0;
      first_vld = -1;
    end else begin
      since_rel++;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 1, 1, 1);
  endtask

  initial begin
    reset = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    jump_enable = 0; jump_address = 0; stall = 0;

    // Zero-wait memory from reset: first valid two cycles after release, then one per cycle.
    do_reset(3);
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0, 1, 1, 1);
    check_val("first_valid_cycle", first_vld, 2);
    check_val("zero_wait_pops", pop_cnt, 10);

    // Decode stalled for 10 cycles: the queue fills and requests stop.
    do_reset(2);
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 1, 1, 1, 1);
    check_val("stall_accepts", acc_cnt, DEPTH);
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 32'h0, 0, 1, 1, 1);
    check_val("post_stall_pops", pop_cnt, 12);

    // Latency 3, two requests in flight, redirect to 'h100.
    do_reset(2);
    step(0, 0, 32'h0, 0, 1, 3, 1);
    step(0, 0, 32'h0, 0, 1, 3, 1);
    step(0, 1, 32'h100, 0, 0, 3, 1);
    got_first_pop = 0;
    for (int i = 0; i < 16; i++) step(0, 0, 32'h0, 0, 1, 3, 1);
    check_val("first_after_jump", first_pop_addr, 32'h100);

    // Redirect coinciding with a response and a pending pop.
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 1, 1);
    step(0, 1, 32'h300, 0, 1, 1, 1);
    got_first_pop = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 1, 1, 1);
    check_val("first_after_jump2", first_pop_addr, 32'h300);

    // Misaligned target and PC wrap-around.
    step(0, 1, 32'h203, 0, 1, 1, 1);
    step(0, 0, 32'h0, 0, 0, 1, 1);
    check_val("aligned_target", imem_addr, 32'h200);
    step(0, 1, 32'hFFFF_FFFC, 0, 1, 1, 1);
    step(0, 0, 32'h0, 0, 1, 1, 1);
    step(0, 0, 32'h0, 0, 0, 1, 1);
    check_val("pc_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 1, 1, 1);

    // Reset with the queue holding filled entries and a request in flight.
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1, 3, 1);
    step(1, 0, 32'h0, 1, 1, 1, 1);
    step(0, 0, 32'h0, 0, 0, 1, 1);
    check_val("post_reset_valid", valid_out, 1'b0);
    check_val("post_reset_addr", imem_addr, RESET_PC);

    // Randomized traffic: stalls, backpressure, variable latency, redirects, resets.
    for (int i = 0; i < 4000; i++) begin
      bit rr, jj;
      rr = ($urandom_range(0, 199) == 0);
      jj = ($urandom_range(0, 29) == 0);
      step(rr, jj, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
           $urandom_range(1, 4), ($urandom_range(0, 9) < 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
